// File: rtl/temp_pio_poller.sv
// rtl/temp_pio_poller.sv - Avalon-MM poller for a 16-bit sensor PIO with hysteretic alarm.
// Optional 4-sample averaging of the reported sample when TEMP_POLL_AVG_EN is defined.
`timescale 1ns/1ps
module temp_pio_poller #(
  parameter logic [31:0] TARGET_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_DIV    = 50000,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [15:0] THRESH_HI   = 16'h0500,
  parameter logic [15:0] THRESH_LO   = 16'h0480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        alarm,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CMD, RESP, SUM, UPDATE} state_t;

`ifdef TEMP_POLL_AVG_EN
  localparam state_t AFTER_RESP = SUM;
`else
  localparam state_t AFTER_RESP = UPDATE;
`endif

  state_t          state, state_nxt;
  logic [23:0]     div;
  logic            tick;
  logic [TW-1:0]   tcnt;
  logic            resp_ok;
  logic            resp_to;
  logic            load;
  logic [15:0]     new_sample;
  logic            unused_hi;

  assign unused_hi   = ^avm_readdata[31:16];
  assign avm_address = TARGET_ADDR;

  // Divider runs freely while enabled; ticks outside IDLE are simply not consumed.
  assign tick = enable && (div == 24'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (!enable || tick) begin
      div <= '0;
    end else begin
      div <= div + 24'd1;
    end
  end

  assign resp_ok = (state == RESP) && avm_readdatavalid;
  assign resp_to = (state == RESP) && !avm_readdatavalid && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (state != RESP) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    avm_read     = 1'b0;
    sample_valid = 1'b0;
    case (state)
      IDLE: begin
        if (tick) state_nxt = CMD;
      end
      CMD: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_nxt = RESP;
      end
      RESP: begin
        if (avm_readdatavalid) state_nxt = AFTER_RESP;
        else if (resp_to)      state_nxt = IDLE;
      end
      SUM: begin
        state_nxt = UPDATE;
      end
      UPDATE: begin
        sample_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TEMP_POLL_AVG_EN
  logic [15:0] hist [4];
  logic [17:0] sum;

  assign sum = 18'(hist[0]) + 18'(hist[1]) + 18'(hist[2]) + 18'(hist[3]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
      hist[3] <= '0;
    end else if (resp_ok) begin
      hist[3] <= hist[2];
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= avm_readdata[15:0];
    end
  end

  assign load       = (state == SUM);
  assign new_sample = sum[17:2];
`else
  assign load       = resp_ok;
  assign new_sample = avm_readdata[15:0];
`endif

  // Outputs are registered on entry to UPDATE so sample is stable while sample_valid is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample      <= '0;
      alarm       <= 1'b0;
      timeout_err <= 1'b0;
    end else if (load) begin
      sample      <= new_sample;
      timeout_err <= 1'b0;
      if (new_sample > THRESH_HI)      alarm <= 1'b1;
      else if (new_sample < THRESH_LO) alarm <= 1'b0;
    end else if (resp_to) begin
      timeout_err <= 1'b1;
    end
  end

endmodule
